// File: rtl/scrambler_pkg.sv
// Shared state encoding, rotation indices and the saturating negate used by
// the symbol scrambler control path and its I/Q rotator.
package scrambler_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [1:0] ROT_0 = 2'd0;
    localparam logic [1:0] ROT_1 = 2'd1;
    localparam logic [1:0] ROT_2 = 2'd2;
    localparam logic [1:0] ROT_3 = 2'd3;

    // Widest component the helper handles; callers sign-extend into this.
    localparam int SAT_MAX_W = 32;

    // Negate a w-bit two's complement value (sign-extended to SAT_MAX_W).
    // The most negative code has no positive twin, so it clamps to max.
    function automatic logic [SAT_MAX_W-1:0] sat_neg(input logic [SAT_MAX_W-1:0] x,
                                                     input int w);
        logic [SAT_MAX_W-1:0] hi;
        logic [SAT_MAX_W-1:0] lo;
        hi = (SAT_MAX_W'(1) << (w - 1)) - SAT_MAX_W'(1);
        lo = ~hi;
        return (x == lo) ? hi : (~x + SAT_MAX_W'(1));
    endfunction

endpackage

// File: rtl/iq_rotate.sv
// Combinational rotation of one complex sample by j^r, with saturating
// negation so no width growth is needed.
module iq_rotate
    import scrambler_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] i,
    input  logic [W-1:0] q,
    input  logic [1:0]   r,
    output logic [W-1:0] i_rot,
    output logic [W-1:0] q_rot
);

    logic [SAT_MAX_W-1:0] i_ext;
    logic [SAT_MAX_W-1:0] q_ext;
    logic [W-1:0]         i_neg;
    logic [W-1:0]         q_neg;

    assign i_ext = {{(SAT_MAX_W-W){i[W-1]}}, i};
    assign q_ext = {{(SAT_MAX_W-W){q[W-1]}}, q};
    assign i_neg = W'(sat_neg(i_ext, W));
    assign q_neg = W'(sat_neg(q_ext, W));

    always_comb begin
        i_rot = i;
        q_rot = q;
        case (r)
            ROT_0: begin i_rot = i;     q_rot = q;     end
            ROT_1: begin i_rot = q_neg; q_rot = i;     end
            ROT_2: begin i_rot = i_neg; q_rot = q_neg; end
            default: begin i_rot = q;   q_rot = i_neg; end
        endcase
    end

endmodule

// File: rtl/symbol_scrambler.sv
// Framed I/Q scrambler: passes HDR_LEN header symbols, rotates data symbols by
// j^R from the randomizer, and steers the randomizer's reset/enable.
module symbol_scrambler
    import scrambler_pkg::*;
#(
    parameter int W       = 8,
    parameter int HDR_LEN = 320
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    input  logic         i_in_sof,
    input  logic [W-1:0] i_in_i,
    input  logic [W-1:0] i_in_q,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic         o_out_sof,
    output logic         o_out_hdr,
    output logic [W-1:0] o_out_i,
    output logic [W-1:0] o_out_q,
    output logic         o_rnd_reset,
    output logic         o_rnd_en,
    input  logic [1:0]   i_rnd_r,
    output logic         o_frame_err
);

    localparam int CW = $clog2(HDR_LEN + 1);
    localparam logic [CW-1:0] HDR_LAST = CW'(HDR_LEN);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          accept;
    logic          fwd;
    logic          hdr_sym;
    logic          err_nxt;
    logic [W-1:0]  rot_i;
    logic [W-1:0]  rot_q;

    // Single output register: we can take a symbol whenever it is empty or
    // being drained this cycle.
    assign o_in_ready = !o_out_valid || i_out_ready;
    assign accept     = i_in_valid && o_in_ready;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // cnt counts header symbols seen, the sof symbol being number one.
    // While in HDR it is always below HDR_LEN, so any sof there is early.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        err_nxt   = 1'b0;
        if (accept) begin
            if (i_in_sof) begin
                cnt_nxt   = CW'(1);
                state_nxt = (HDR_LEN == 1) ? DATA : HDR;
                err_nxt   = (state == HDR);
            end else if (state == HDR) begin
                cnt_nxt = cnt + CW'(1);
                if (cnt_nxt == HDR_LAST) state_nxt = DATA;
            end
        end
    end

    always_comb begin
        fwd         = accept && (i_in_sof || state != IDLE);
        hdr_sym     = i_in_sof || state == HDR;
        o_rnd_reset = i_reset || (accept && i_in_sof);
        o_rnd_en    = !i_reset && accept && (state == DATA) && !i_in_sof;
    end

    iq_rotate #(.W(W)) u_rot (
        .i     (i_in_i),
        .q     (i_in_q),
        .r     (i_rnd_r),
        .i_rot (rot_i),
        .q_rot (rot_q)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_out_valid <= 1'b0;
            o_out_sof   <= 1'b0;
            o_out_hdr   <= 1'b0;
            o_out_i     <= '0;
            o_out_q     <= '0;
            o_frame_err <= 1'b0;
        end else begin
            o_frame_err <= err_nxt;
            if (o_in_ready) begin
                o_out_valid <= fwd;
                if (fwd) begin
                    o_out_sof <= i_in_sof;
                    o_out_hdr <= hdr_sym;
                    o_out_i   <= hdr_sym ? i_in_i : rot_i;
                    o_out_q   <= hdr_sym ? i_in_q : rot_q;
                end
            end
        end
    end

endmodule
